// File: rtl/aes_pkg.sv
// Shared AES definitions: key-size mode encodings, schedule geometry per mode,
// controller state encoding and the GF(2^8) xtime helper.
package aes_pkg;

  typedef enum logic [1:0] {
    MODE_128 = 2'd0,
    MODE_192 = 2'd1,
    MODE_256 = 2'd2,
    MODE_ILL = 2'd3
  } aes_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_KEYEXP = 3'd1,
    ST_LOAD   = 3'd2,
    ST_ROUND  = 3'd3,
    ST_DONE   = 3'd4
  } aes_state_e;

  localparam logic [5:0] NK_128 = 6'd4;
  localparam logic [5:0] NK_192 = 6'd6;
  localparam logic [5:0] NK_256 = 6'd8;
  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  function automatic logic [5:0] nk_of(input logic [1:0] mode);
    logic [5:0] nk;
    case (mode)
      MODE_128: nk = NK_128;
      MODE_192: nk = NK_192;
      default:  nk = NK_256;
    endcase
    return nk;
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] mode);
    logic [3:0] nr;
    case (mode)
      MODE_128: nr = NR_128;
      MODE_192: nr = NR_192;
      default:  nr = NR_256;
    endcase
    return nr;
  endfunction

  // Index of the final schedule word, 4*(Nr+1)-1.
  function automatic logic [5:0] last_word_of(input logic [1:0] mode);
    logic [5:0] last;
    case (mode)
      MODE_128: last = 6'd43;
      MODE_192: last = 6'd51;
      default:  last = 6'd59;
    endcase
    return last;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// Round-constant register: restarts at 01 on init and doubles in GF(2^8) on adv.
module aes_rcon_gen
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       init,
  input  logic       adv,
  output logic [7:0] rcon
);

  logic [7:0] rcon_d;
  logic [7:0] rcon_q;

  // Next constant: init wins over advance.
  always_comb begin
    rcon_d = rcon_q;
    if (init) begin
      rcon_d = 8'h01;
    end else if (adv) begin
      rcon_d = xtime(rcon_q);
    end else begin
      rcon_d = rcon_q;
    end
  end

  // Constant register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rcon_q <= 8'h01;
    end else begin
      rcon_q <= rcon_d;
    end
  end

  assign rcon = rcon_q;

endmodule

// File: rtl/aes_round_scheduler.sv
// AES-128/192/256 sequencing controller: key expansion, initial AddRoundKey and
// one round per cycle, with an optional cache of the expanded schedule.
module aes_round_scheduler
  import aes_pkg::*;
#(
  parameter int unsigned KEY_CACHE = 1
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic [1:0] mode,
  input  logic       start,
  input  logic       key_load,
  output logic       busy,
  output logic       done,
  output logic       mode_err,
  output logic       key_word_en,
  output logic [5:0] key_word_idx,
  output logic       key_rot_sub,
  output logic       key_sub_only,
  output logic [7:0] rcon,
  output logic       init_add_en,
  output logic       round_en,
  output logic [3:0] round_idx,
  output logic       final_round
);

  aes_state_e state_d, state_q;
  logic [1:0] mode_d, mode_q;
  logic [5:0] word_idx_d, word_idx_q;
  logic [2:0] pos_d, pos_q;
  logic [3:0] round_d, round_q;
  logic       cache_valid_d, cache_valid_q;
  logic [1:0] cached_mode_d, cached_mode_q;
  logic       kl_seen_d, kl_seen_q;
  logic       mode_err_d, mode_err_q;

  logic       rcon_init_s;
  logic       rcon_adv_s;
  logic [7:0] rcon_s;
  logic [5:0] nk_s;
  logic [3:0] nr_s;
  logic [5:0] last_s;
  logic       hit_s;
  logic       rot_sub_s;

  assign nk_s   = nk_of(mode_q);
  assign nr_s   = nr_of(mode_q);
  assign last_s = last_word_of(mode_q);

  // pos_q tracks i mod Nk without a divider; it restarts at 0 on word Nk.
  assign rot_sub_s = (state_q == ST_KEYEXP) && (pos_q == 3'd0);

  // A key_load coinciding with start forces a fresh expansion.
  assign hit_s = (KEY_CACHE != 32'd0) && cache_valid_q && (cached_mode_q == mode) && !key_load;

  aes_rcon_gen u_rcon (
    .clk   (CLK),
    .reset (reset),
    .init  (rcon_init_s),
    .adv   (rcon_adv_s),
    .rcon  (rcon_s)
  );

  // Next-state and counter logic.
  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    word_idx_d    = word_idx_q;
    pos_d         = pos_q;
    round_d       = round_q;
    cache_valid_d = cache_valid_q & ~key_load;
    cached_mode_d = cached_mode_q;
    kl_seen_d     = kl_seen_q | key_load;
    mode_err_d    = 1'b0;
    rcon_init_s   = 1'b0;
    rcon_adv_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (mode == MODE_ILL) begin
            mode_err_d = 1'b1;
          end else begin
            mode_d    = mode;
            kl_seen_d = 1'b0;
            if (hit_s) begin
              state_d = ST_LOAD;
            end else begin
              state_d     = ST_KEYEXP;
              word_idx_d  = nk_of(mode);
              pos_d       = 3'd0;
              rcon_init_s = 1'b1;
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_KEYEXP: begin
        rcon_adv_s = rot_sub_s;
        if (word_idx_q == last_s) begin
          state_d       = ST_LOAD;
          word_idx_d    = 6'd0;
          pos_d         = 3'd0;
          // A key written at any point of this expansion leaves the cache stale.
          cache_valid_d = ~(kl_seen_q | key_load);
          cached_mode_d = mode_q;
        end else begin
          word_idx_d = word_idx_q + 6'd1;
          if ({3'b000, pos_q} == (nk_s - 6'd1)) begin
            pos_d = 3'd0;
          end else begin
            pos_d = pos_q + 3'd1;
          end
        end
      end
      ST_LOAD: begin
        state_d = ST_ROUND;
        round_d = 4'd1;
      end
      ST_ROUND: begin
        if (round_q == nr_s) begin
          state_d = ST_DONE;
          round_d = 4'd0;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Controller state registers.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      mode_q        <= MODE_128;
      word_idx_q    <= 6'd0;
      pos_q         <= 3'd0;
      round_q       <= 4'd0;
      cache_valid_q <= 1'b0;
      cached_mode_q <= MODE_128;
      kl_seen_q     <= 1'b0;
      mode_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      word_idx_q    <= word_idx_d;
      pos_q         <= pos_d;
      round_q       <= round_d;
      cache_valid_q <= cache_valid_d;
      cached_mode_q <= cached_mode_d;
      kl_seen_q     <= kl_seen_d;
      mode_err_q    <= mode_err_d;
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign mode_err     = mode_err_q;
  assign key_word_en  = (state_q == ST_KEYEXP);
  assign key_word_idx = word_idx_q;
  assign key_rot_sub  = rot_sub_s;
  assign key_sub_only = (state_q == ST_KEYEXP) && (nk_s == NK_256) && (pos_q == 3'd4);
  assign rcon         = (state_q == ST_KEYEXP) ? rcon_s : 8'h00;
  assign init_add_en  = (state_q == ST_LOAD);
  assign round_en     = (state_q == ST_ROUND);
  assign round_idx    = round_q;
  assign final_round  = (state_q == ST_ROUND) && (round_q == nr_s);

endmodule

// File: tb/tb_aes_round_scheduler.sv
// Self-checking bench: table-driven and randomized blocks compared per cycle
// against a trace model derived from the AES key-schedule arithmetic.
module tb_aes_round_scheduler;

  logic       CLK = 1'b0;
  logic       reset;
  logic [1:0] mode;
  logic       start;
  logic       key_load;
  logic       busy, done, mode_err, key_word_en, key_rot_sub, key_sub_only;
  logic [5:0] key_word_idx;
  logic [7:0] rcon;
  logic       init_add_en, round_en, final_round;
  logic [3:0] round_idx;
  logic [26:0] obs;

  always #5 CLK = ~CLK;

  aes_round_scheduler #(.KEY_CACHE(1)) dut (
    .CLK          (CLK),
    .reset        (reset),
    .mode         (mode),
    .start        (start),
    .key_load     (key_load),
    .busy         (busy),
    .done         (done),
    .mode_err     (mode_err),
    .key_word_en  (key_word_en),
    .key_word_idx (key_word_idx),
    .key_rot_sub  (key_rot_sub),
    .key_sub_only (key_sub_only),
    .rcon         (rcon),
    .init_add_en  (init_add_en),
    .round_en     (round_en),
    .round_idx    (round_idx),
    .final_round  (final_round)
  );

  assign obs = {busy, done, mode_err, key_word_en, key_word_idx, key_rot_sub, key_sub_only,
                rcon, init_add_en, round_en, round_idx, final_round};

  int checks = 0;
  int errors = 0;
  bit model_valid = 1'b0;
  int model_mode = 0;
  logic [7:0] rc_tab [12];

  typedef struct {
    int m;
    int xs_k;
    int kl_k;
    int rst_k;
    int lat;
  } vec_t;
  vec_t vecs [9];

  function automatic int nk_f(int m);
    return (m == 0) ? 4 : (m == 1) ? 6 : 8;
  endfunction

  function automatic int nr_f(int m);
    return (m == 0) ? 10 : (m == 1) ? 12 : 14;
  endfunction

  function automatic int words_f(int m, bit cached);
    return cached ? 0 : (4 * (nr_f(m) + 1) - nk_f(m));
  endfunction

  function automatic int lat_f(int m, bit cached);
    return words_f(m, cached) + nr_f(m) + 2;
  endfunction

  // Expected output vector k cycles after the accepting edge.
  function automatic logic [26:0] exp_at(int k, int m, bit cached);
    int nk, nr, nw, i, r;
    logic rot, sub;
    logic [5:0] idx;
    logic [3:0] ri;
    logic [7:0] rc;
    nk = nk_f(m);
    nr = nr_f(m);
    nw = words_f(m, cached);
    if (k >= 1 && k <= nw) begin
      i   = nk + k - 1;
      idx = 6'(i);
      rot = ((i % nk) == 0);
      sub = (nk == 8) && ((i % 8) == 4);
      rc  = rc_tab[(i - 1) / nk];
      return {1'b1, 1'b0, 1'b0, 1'b1, idx, rot, sub, rc, 1'b0, 1'b0, 4'd0, 1'b0};
    end else if (k == nw + 1) begin
      return {1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 1'b0};
    end else if (k >= nw + 2 && k <= nw + 1 + nr) begin
      r  = k - nw - 1;
      ri = 4'(r);
      return {1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, ri, (r == nr)};
    end else if (k == nw + nr + 2) begin
      return {1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0};
    end else begin
      return 27'd0;
    end
  endfunction

  task automatic check(input string name, input logic [26:0] got, input logic [26:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, want);
    end
  endtask

  // One block: start at the next edge, compare every cycle, optional disturbances.
  task automatic run_block(input int m, input int xs_k, input int kl_k, input int rst_k,
                           input int want_lat, input string tag);
    bit cached;
    bit kl_seen;
    int lat;
    int first_done;
    cached     = model_valid && (model_mode == m);
    lat        = lat_f(m, cached);
    kl_seen    = 1'b0;
    first_done = 0;
    @(negedge CLK);
    mode  = 2'(m);
    start = 1'b1;
    for (int k = 1; k <= lat + 1; k++) begin
      @(posedge CLK);
      #1;
      if (rst_k != 0 && k == rst_k + 1) begin
        check({tag, "_reset"}, obs, 27'd0);
        model_valid = 1'b0;
        break;
      end
      check(tag, obs, exp_at(k, m, cached));
      if (done && first_done == 0) first_done = k;
      start    = (k == xs_k);
      mode     = 2'($urandom_range(0, 3));
      key_load = (k == kl_k);
      if (k == kl_k) kl_seen = 1'b1;
      reset    = (k != rst_k);
    end
    start    = 1'b0;
    key_load = 1'b0;
    reset    = 1'b1;
    if (rst_k == 0) begin
      checks++;
      if (first_done != want_lat) begin
        errors++;
        $display("FAIL %s_latency got %0d exp %0d", tag, first_done, want_lat);
      end
      model_valid = !kl_seen;
      model_mode  = m;
    end
  endtask

  initial begin
    rc_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
               8'h1B, 8'h36, 8'h6C, 8'hD8};
    // {mode, extra start cycle, key_load cycle, reset cycle, done latency}
    vecs[0] = '{0,  0,  0, 0, 52};
    vecs[1] = '{0, 12,  0, 0, 12};
    vecs[2] = '{2,  0,  0, 0, 68};
    vecs[3] = '{1, 50,  0, 0, 60};
    vecs[4] = '{0,  0, 10, 0, 52};
    vecs[5] = '{0,  0,  0, 0, 52};
    vecs[6] = '{0,  0,  0, 0, 12};
    vecs[7] = '{0,  0,  0, 5,  0};
    vecs[8] = '{0,  0,  0, 0, 52};

    reset    = 1'b0;
    start    = 1'b0;
    key_load = 1'b0;
    mode     = 2'd0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_state", obs, 27'd0);
    reset = 1'b1;

    for (int v = 0; v < 9; v++) begin
      if (v == 3) begin
        @(negedge CLK);
        mode  = 2'd3;
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        check("mode_err_pulse", obs, {3'b001, 24'd0});
        @(posedge CLK);
        #1;
        check("mode_err_clear", obs, 27'd0);
      end
      run_block(vecs[v].m, vecs[v].xs_k, vecs[v].kl_k, vecs[v].rst_k, vecs[v].lat,
                $sformatf("vec%0d", v));
    end

    for (int n = 0; n < 12; n++) begin
      int m, lat, xs, kl;
      m   = $urandom_range(0, 2);
      lat = lat_f(m, model_valid && (model_mode == m));
      xs  = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, lat);
      kl  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, lat) : 0;
      run_block(m, xs, kl, 0, lat, $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_round_scheduler.md
Name: aes_round_scheduler

Overview:
Controller that sequences the AES datapath for AES-128/192/256 (mode 0/1/2). On a start request it runs key expansion one word per cycle, then the initial AddRoundKey, then one round per cycle. It drives word/round indices, Rcon and per-phase enables to the key-expansion and round datapaths. It caches the expanded schedule so repeated blocks under the same key skip expansion.

Parameters:
KEY_CACHE, 1, 1 = reuse expanded schedule when key/mode unchanged; 0 = always expand

Ports:
CLK  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
mode  input  2  0=AES-128, 1=AES-192, 2=AES-256, 3=illegal; sampled only when start is accepted
start  input  1  request one block; accepted only in IDLE
key_load  input  1  new key written; invalidates cache (any state)
busy  output  1  high from the cycle after acceptance through the DONE cycle
done  output  1  one-cycle pulse, block complete
mode_err  output  1  one-cycle pulse, start with mode=3 (rejected)
key_word_en  output  1  key datapath computes word key_word_idx this cycle
key_word_idx  output  6  word index i, Nk..4*(Nr+1)-1
key_rot_sub  output  1  i mod Nk == 0 (RotWord+SubWord+Rcon)
key_sub_only  output  1  Nk==8 and i mod 8 == 4 (SubWord only)
rcon  output  8  round constant for the current word
init_add_en  output  1  initial AddRoundKey with round key 0
round_en  output  1  round datapath active
round_idx  output  4  current round, 0 in LOAD, 1..Nr in ROUND
final_round  output  1  round_en and round_idx==Nr (omit MixColumns)

Behaviour:
- Nk/Nr by latched mode: 4/10, 6/12, 8/14. Last word index 43/51/59.
- States: IDLE, KEYEXP, LOAD, ROUND, DONE.
- IDLE: start with mode<3 latches mode -> KEYEXP if cache invalid, latched mode differs from cached mode, or KEY_CACHE=0; otherwise -> LOAD. start with mode=3: stay IDLE, mode_err=1 for one cycle.
- KEYEXP: key_word_en=1, key_word_idx runs Nk..last, one per cycle. Counts are 40/46/52 cycles. rcon=01 for the first word. rcon advances by xtime (x2 mod 0x11B) after each word with key_rot_sub=1. After the last word: cache_valid<=1, cached_mode<=mode -> LOAD.
- LOAD: one cycle, init_add_en=1, round_idx=0 -> ROUND.
- ROUND: round_en=1, round_idx 1..Nr, one per cycle. final_round on the Nr cycle -> DONE.
- DONE: done=1, busy=1, one cycle -> IDLE. start is never accepted in the DONE cycle.
- Latency (start sampled in IDLE at cycle t): uncached AES-128 done at t+52, AES-192 t+60, AES-256 t+68. Cached: done at t+2+Nr.
- start outside IDLE is ignored, with no queueing. mode changes while busy are ignored.
- key_load during KEYEXP: the current expansion completes, but cache_valid ends at 0. The next start re-expands.
- key_load in the same cycle as an accepted start: the start is treated as uncached.
- Reset (reset==0 at a clock edge), including mid-operation: state=IDLE, cache_valid=0, all outputs 0, rcon=00, indices 0.
- All outputs are registered or decoded from registered state only. There is no combinational path from start to any output.

Decomposition:
- Shared package aes_pkg: mode encodings, NK/NR lookup constants, state encoding, the xtime function. The round datapath reuses xtime.
- One sub-module, aes_rcon_gen: 8-bit register with reset-to-01 and advance enable, output rcon.

Test Plan:
- Reset, mode=0, start pulse -> key_word_idx 4..43 over 40 cycles, rcon sequence 01,02,04,08,10,20,40,80,1B,36 on i=4,8,...,40; done at t+52; busy high t+1..t+52.
- Repeat start, mode=0, no key_load -> no key_word_en; init_add_en at t+1, round_idx 1..10 at t+2..t+11, final_round at t+11, done at t+12.
- mode=2 start after mode=0 run -> full expansion, 52 words; key_rot_sub at i=8,16,...,56; key_sub_only at i=12,20,...,52; last rcon 40; done at t+68.
- mode=3 start -> mode_err single pulse, busy stays 0. Then start during ROUND of a mode=1 run -> ignored; done at t+60 only.
- key_load during KEYEXP, then a second start -> second run re-expands (key_word_en present).
- reset low mid-ROUND -> next cycle all outputs 0 and state IDLE; following start expands.
